// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment readback monitor.
// Segment patterns are gfedcba, active-low (a lit segment reads 0).
package seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Hex glyphs 0..F as produced by the display driver
   localparam seg_t SEG_GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      ST_SAMPLE = 2'd0,
      ST_SETTLE = 2'd1,
      ST_EMIT   = 2'd2
   } rd_state_t;

   typedef struct packed {
      logic [3:0] value;
      logic       blank;
      logic       invalid;
   } seg_result_t;

endpackage

// File: rtl/seven_segment_encoder.sv
// Pattern-to-result converter: maps an active-low segment pattern back to
// its hex value, flagging all-off patterns as blank and anything else that
// is not a glyph as invalid.
module seven_segment_encoder
   import seg_pkg::*;
(
   input  seg_t        seg,
   output seg_result_t res
);

   // Table lookup; glyphs are unique so at most one entry matches
   always_comb begin
      res         = '0;
      res.invalid = 1'b1;
      if (seg == SEG_BLANK) begin
         res.blank   = 1'b1;
         res.invalid = 1'b0;
      end else begin
         for (int v = 0; v < 16; v++) begin
            if (seg == SEG_GLYPH[v]) begin
               res.value   = 4'(v);
               res.invalid = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/seven_segment_reader.sv
// Scanning readback monitor for the common-anode seven-segment displays.
// Walks the digits in turn, waits for each pattern to stay unchanged for
// STABLE_CYCLES samples, decodes it and presents it on a valid/ready stream.
// Optional build macro SEVEN_SEG_READER_CHANGE_ONLY_EN: remember the last
// result per digit and only emit digits whose decoded result has changed.
module seven_segment_reader
   import seg_pkg::*;
#(
   parameter  int NUM_DIGITS    = 6,
   parameter  int STABLE_CYCLES = 4,
   localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [7*NUM_DIGITS-1:0] seg_bus,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [IDX_W-1:0]        out_digit_idx,
   output logic [3:0]              out_value,
   output logic                    out_blank,
   output logic                    out_invalid,
   output logic                    scan_done
);

   localparam logic [7:0]       CNT_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   rd_state_t        state;
   logic [IDX_W-1:0] idx;
   logic [7:0]       cnt;
   seg_t             lat;
   seg_t             cur;
   seg_result_t      lat_res;
   logic             idx_wrap;
   logic [IDX_W-1:0] idx_next;
   logic             skip_emit;

   // Select the pattern of the digit currently being scanned
   always_comb begin
      cur = SEG_BLANK;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) cur = seg_bus[7*k +: 7];
      end
   end

   assign idx_wrap = (idx == IDX_LAST);
   assign idx_next = idx_wrap ? '0 : idx + 1'b1;

   // Decoding works on the latched pattern, which equals the live one
   // whenever the stability count completes.
   seven_segment_encoder u_enc (
      .seg (lat),
      .res (lat_res)
   );

`ifdef SEVEN_SEG_READER_CHANGE_ONLY_EN
   logic [NUM_DIGITS-1:0] seen;
   seg_result_t           rec [NUM_DIGITS];

   assign skip_emit = seen[idx] && (rec[idx] == lat_res);
`else
   assign skip_emit = 1'b0;
`endif

   // Scan FSM with registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_SAMPLE;
         idx           <= '0;
         cnt           <= '0;
         lat           <= SEG_BLANK;
         out_valid     <= 1'b0;
         out_digit_idx <= '0;
         out_value     <= '0;
         out_blank     <= 1'b0;
         out_invalid   <= 1'b0;
         scan_done     <= 1'b0;
`ifdef SEVEN_SEG_READER_CHANGE_ONLY_EN
         seen          <= '0;
         for (int k = 0; k < NUM_DIGITS; k++) rec[k] <= '0;
`endif
      end else begin
         scan_done <= 1'b0;
         unique case (state)
            ST_SAMPLE: begin
               if (enable) begin
                  lat   <= cur;
                  cnt   <= 8'd1;
                  state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (!enable) begin
                  state <= ST_SAMPLE;
               end else if (cur != lat) begin
                  lat <= cur;
                  cnt <= 8'd1;
               end else if (cnt == CNT_LAST) begin
                  cnt <= cnt + 8'd1;
                  if (skip_emit) begin
                     // Unchanged digit: move straight on to the next one
                     idx       <= idx_next;
                     scan_done <= idx_wrap;
                     state     <= ST_SAMPLE;
                  end else begin
                     out_valid     <= 1'b1;
                     out_digit_idx <= idx;
                     out_value     <= lat_res.value;
                     out_blank     <= lat_res.blank;
                     out_invalid   <= lat_res.invalid;
                     state         <= ST_EMIT;
`ifdef SEVEN_SEG_READER_CHANGE_ONLY_EN
                     seen[idx]     <= 1'b1;
                     rec[idx]      <= lat_res;
`endif
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_EMIT: begin
               // Result stays frozen until the consumer takes it
               if (out_ready) begin
                  out_valid <= 1'b0;
                  idx       <= idx_next;
                  scan_done <= idx_wrap;
                  state     <= ST_SAMPLE;
               end
            end
            default: state <= ST_SAMPLE;
         endcase
      end
   end

endmodule
